// File: rtl/ldr_unit.sv
// Load unit: takes one LDR/LDRB request, reads the containing word from memory,
// formats it and writes it to the register bank, or aborts after TIMEOUT cycles.
module ldr_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ldr_req,
    output logic        ldr_ready,
    input  logic [3:0]  ldr_rd,
    input  logic [31:0] ldr_addr,
    input  logic        ldr_byte,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] enable,
    output logic [31:0] ldr_data,
    output logic        memory_enable,
    output logic        ldr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WB   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_rd;
    logic [31:0] r_addr;
    logic        r_byte;
    logic [7:0]  r_cnt;
    logic [31:0] r_data;
    logic        w_accept;
    logic        w_ack;
    logic        w_expire;

    // Little-endian byte lane select with zero extension; word loads pass through.
    function automatic logic [31:0] fmt_data(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic        is_byte);
        logic [31:0] res;
        if (!is_byte) begin
            res = d;
        end else begin
            case (off)
                2'd0:    res = {24'd0, d[7:0]};
                2'd1:    res = {24'd0, d[15:8]};
                2'd2:    res = {24'd0, d[23:16]};
                2'd3:    res = {24'd0, d[31:24]};
                default: res = 32'd0;
            endcase
        end
        return res;
    endfunction

    assign w_accept = (r_state == S_IDLE) && ldr_req;
    assign w_ack    = (r_state == S_READ) && mem_ack;
    // The cycle that would be the TIMEOUT-th without an ack; an ack here still wins.
    assign w_expire = (r_cnt == TIMEOUT_LAST);
    assign mem_addr = {r_addr[31:2], 2'b00};
    assign ldr_data = r_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_READ;
                else          w_next = S_IDLE;
            end
            S_READ: begin
                if (w_ack)         w_next = S_WB;
                else if (w_expire) w_next = S_ERR;
                else               w_next = S_READ;
            end
            S_WB:    w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ldr_ready     = 1'b0;
        mem_rd_en     = 1'b0;
        enable        = 16'd0;
        memory_enable = 1'b0;
        ldr_err       = 1'b0;
        case (r_state)
            S_IDLE: ldr_ready = 1'b1;
            S_READ: mem_rd_en = 1'b1;
            S_WB: begin
                memory_enable = 1'b1;
                enable        = 16'd1 << r_rd;
            end
            S_ERR:   ldr_err   = 1'b1;
            default: ldr_ready = 1'b0;
        endcase
    end

    // Request capture, timeout counter and load-result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd   <= 4'd0;
            r_addr <= 32'd0;
            r_byte <= 1'b0;
            r_cnt  <= 8'd0;
            r_data <= 32'd0;
        end else if (w_accept) begin
            r_rd   <= ldr_rd;
            r_addr <= ldr_addr;
            r_byte <= ldr_byte;
            r_cnt  <= 8'd0;
        end else if (w_ack) begin
            r_data <= fmt_data(mem_rdata, r_addr[1:0], r_byte);
        end else if (r_state == S_READ) begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ldr_unit.sv
// Directed bench for ldr_unit with a writeback scoreboard.
module tb_ldr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ldr_req;
    logic        ldr_ready;
    logic [3:0]  ldr_rd;
    logic [31:0] ldr_addr;
    logic        ldr_byte;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] enable;
    logic [31:0] ldr_data;
    logic        memory_enable;
    logic        ldr_err;

    int total = 0;
    int bad   = 0;
    int wb_count = 0;
    logic [35:0] sb[$];

    ldr_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ldr_req(ldr_req), .ldr_ready(ldr_ready),
        .ldr_rd(ldr_rd), .ldr_addr(ldr_addr), .ldr_byte(ldr_byte),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .enable(enable), .ldr_data(ldr_data),
        .memory_enable(memory_enable), .ldr_err(ldr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic request(input logic [3:0] rd, input logic [31:0] addr, input logic is_byte);
        ldr_req  = 1'b1;
        ldr_rd   = rd;
        ldr_addr = addr;
        ldr_byte = is_byte;
        step();
        ldr_req  = 1'b0;
    endtask

    // Scoreboard: every writeback must match the oldest expected load.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && memory_enable === 1'b1) begin
            logic [35:0] e;
            wb_count++;
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_enable", {16'd0, enable}, {16'd0, 16'd1 << e[35:32]});
                chk("wb_data", ldr_data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n_rd, n_err, n_wb, n_en, wb0;
        rst_n = 1'b0; ldr_req = 1'b0; ldr_rd = 4'd0; ldr_addr = 32'd0;
        ldr_byte = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        step(); step();
        chk("rst_ready", {31'd0, ldr_ready}, 32'd1);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_enable", {16'd0, enable}, 32'd0);
        chk("rst_data", ldr_data, 32'd0);
        chk("rst_men", {30'd0, memory_enable, ldr_err}, 32'd0);

        // Word load, request right after reset release.
        rst_n = 1'b1;
        request(4'd5, 32'h0000_0104, 1'b0);
        chk("w_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("w_addr", mem_addr, 32'h0000_0104);
        chk("w_ready", {31'd0, ldr_ready}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sb.push_back({4'd5, 32'hDEAD_BEEF});
        step();
        mem_ack = 1'b0;
        chk("w_men", {31'd0, memory_enable}, 32'd1);
        chk("w_enable", {16'd0, enable}, 32'h0000_0020);
        step();
        chk("w_ready_back", {31'd0, ldr_ready}, 32'd1);
        chk("w_men_low", {31'd0, memory_enable}, 32'd0);
        chk("w_data_hold", ldr_data, 32'hDEAD_BEEF);

        // Byte load, lane 3.
        request(4'd15, 32'h0000_0203, 1'b1);
        chk("b_addr", mem_addr, 32'h0000_0200);
        mem_ack = 1'b1; mem_rdata = 32'hA1B2_C3D4;
        sb.push_back({4'd15, 32'h0000_00A1});
        step(); mem_ack = 1'b0;
        chk("b_enable", {16'd0, enable}, 32'h0000_8000);
        step();

        // Byte load, lane 1, ack after a few wait cycles.
        request(4'd0, 32'h0000_0011, 1'b1);
        step(); step(); step();
        chk("b1_addr", mem_addr, 32'h0000_0010);
        mem_ack = 1'b1; mem_rdata = 32'hA1B2_C3D4;
        sb.push_back({4'd0, 32'h0000_00C3});
        step(); mem_ack = 1'b0;
        step();

        // Timeout with no ack.
        wb0 = wb_count;
        request(4'd2, 32'h0000_0300, 1'b0);
        n_rd = 0; n_err = 0; n_wb = 0; n_en = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd_en) n_rd++;
            if (ldr_err) n_err++;
            if (memory_enable) n_wb++;
            if (enable != 16'd0) n_en++;
            step();
        end
        chk("to_rd_cycles", 32'(n_rd), 32'd15);
        chk("to_err_pulse", 32'(n_err), 32'd1);
        chk("to_no_wb", 32'(n_wb), 32'd0);
        chk("to_no_enable", 32'(n_en), 32'd0);
        chk("to_ready", {31'd0, ldr_ready}, 32'd1);
        chk("to_data_hold", ldr_data, 32'h0000_00C3);

        // Ack on the 15th READ cycle wins over the timeout.
        request(4'd9, 32'h0000_0400, 1'b0);
        for (int i = 0; i < 14; i++) step();
        chk("ex_rd_en", {31'd0, mem_rd_en}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        sb.push_back({4'd9, 32'h1357_9BDF});
        step(); mem_ack = 1'b0;
        chk("ex_men", {31'd0, memory_enable}, 32'd1);
        chk("ex_no_err", {31'd0, ldr_err}, 32'd0);
        step();
        chk("ex_no_err2", {31'd0, ldr_err}, 32'd0);
        chk("ex_ready", {31'd0, ldr_ready}, 32'd1);

        // Stray ack in IDLE, then a second request while busy.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step(); mem_ack = 1'b0;
        chk("stray_ready", {31'd0, ldr_ready}, 32'd1);
        chk("stray_data", ldr_data, 32'h1357_9BDF);
        chk("stray_rd_en", {31'd0, mem_rd_en}, 32'd0);
        wb0 = wb_count;
        request(4'd3, 32'h0000_0040, 1'b0);
        request(4'd10, 32'h0000_0080, 1'b1);
        chk("busy_addr", mem_addr, 32'h0000_0040);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        sb.push_back({4'd3, 32'h1234_5678});
        step(); mem_ack = 1'b0;
        step(); step(); step();
        chk("busy_one_wb", 32'(wb_count - wb0), 32'd1);
        chk("busy_idle", {31'd0, mem_rd_en}, 32'd0);

        // Asynchronous reset in the middle of READ.
        wb0 = wb_count;
        request(4'd7, 32'h0000_0500, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("ar_ready", {31'd0, ldr_ready}, 32'd1);
        chk("ar_addr", mem_addr, 32'd0);
        chk("ar_data", ldr_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step(); mem_ack = 1'b0;
        step(); step();
        chk("ar_no_wb", 32'(wb_count - wb0), 32'd0);
        chk("ar_idle", {31'd0, ldr_ready}, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
